processor: RTL and testbench

PROCESSOR -- requirements
Module: processor

---
 rtl/processor_pkg.sv | 42 ++++
 rtl/processor_alu.sv | 98 +++++++++
 rtl/processor.sv | 132 +++++++++++++
 tb/tb_processor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared constants and types for the processor: data width, MIPS opcode/funct values, ALU operations.
package processor_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;
  localparam int BUF_N  = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_PASS_B
  } alu_op_e;

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational decode + ALU for one instruction word. Unsupported encodings decode to ALU_NOP
// and produce no write and a zero result.
module processor_alu
  import processor_pkg::*;
(
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] rd,
  output logic              wen
);

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [REG_AW-1:0] rt_field;
  logic [REG_AW-1:0] rd_field;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] operand_b;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] value;
  logic              unused_shamt;

  assign op           = inst[31:26];
  assign funct        = inst[5:0];
  assign imm          = inst[15:0];
  assign rt_field     = inst[20:16];
  assign rd_field     = inst[15:11];
  assign unused_shamt = ^inst[10:6];

  always_comb begin
    alu_op    = ALU_NOP;
    operand_b = '0;
    dest      = '0;
    case (op)
      OP_RTYPE: begin
        dest      = rd_field;
        operand_b = rt_data;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          default: alu_op = ALU_NOP;
        endcase
      end
      OP_ADDI: begin
        alu_op    = ALU_ADD;
        dest      = rt_field;
        operand_b = sext16(imm);
      end
      OP_ANDI: begin
        alu_op    = ALU_AND;
        dest      = rt_field;
        operand_b = zext16(imm);
      end
      OP_ORI: begin
        alu_op    = ALU_OR;
        dest      = rt_field;
        operand_b = zext16(imm);
      end
      OP_XORI: begin
        alu_op    = ALU_XOR;
        dest      = rt_field;
        operand_b = zext16(imm);
      end
      OP_LUI: begin
        alu_op    = ALU_PASS_B;
        dest      = rt_field;
        operand_b = {imm, 16'h0000};
      end
      default: alu_op = ALU_NOP;
    endcase
  end

  // ADD/SUB wrap silently; there is no overflow trap.
  always_comb begin
    value = '0;
    case (alu_op)
      ALU_ADD:    value = rs_data + operand_b;
      ALU_SUB:    value = rs_data - operand_b;
      ALU_AND:    value = rs_data & operand_b;
      ALU_OR:     value = rs_data | operand_b;
      ALU_XOR:    value = rs_data ^ operand_b;
      ALU_NOR:    value = ~(rs_data | operand_b);
      ALU_PASS_B: value = operand_b;
      default:    value = '0;
    endcase
  end

  assign result = value;
  assign rd     = (alu_op != ALU_NOP) ? dest : '0;
  assign wen    = (alu_op != ALU_NOP) && (dest != '0);

endmodule

// File: rtl/processor.sv
// Single-issue in-order processor: 4-word fetch buffer, 32x32 register file, one retirement per cycle.
// Define PROCESSOR_PREFETCH_EN to refill the buffer while its last instruction retires.
module processor
  import processor_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       inst_address,
  output logic              InstMem_Read,
  input  logic              InstMem_Ready,
  input  logic [31:0]       inst1_in,
  input  logic [31:0]       inst2_in,
  input  logic [31:0]       inst3_in,
  input  logic [31:0]       inst4_in,
  output logic              commit,
  output logic [31:0]       commit_pc,
  output logic              commit_wen,
  output logic [REG_AW-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data
);

  // PCs are kept as word addresses so the byte address is aligned by construction.
  logic [29:0]       fetch_pc_q, fetch_pc_d;
  logic [29:0]       block_pc_q, block_pc_d;
  logic [1:0]        head_q, head_d;
  logic [2:0]        count_q, count_d;
  logic [DATA_W-1:0] buf_q [BUF_N];
  logic [DATA_W-1:0] rf_q  [NREGS];

  logic [DATA_W-1:0] fetch_word [BUF_N];
  logic              fetch_req;
  logic              load;
  logic              retire;
  logic [DATA_W-1:0] head_inst;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] alu_result;
  logic [REG_AW-1:0] alu_rd;
  logic              alu_wen;

  assign fetch_word[0] = inst1_in;
  assign fetch_word[1] = inst2_in;
  assign fetch_word[2] = inst3_in;
  assign fetch_word[3] = inst4_in;

`ifdef PROCESSOR_PREFETCH_EN
  assign fetch_req = !rst && ((count_q == 3'd0) || (count_q == 3'd1));
`else
  assign fetch_req = !rst && (count_q == 3'd0);
`endif

  assign load         = fetch_req && InstMem_Ready;
  assign retire       = !rst && (count_q != 3'd0);
  assign InstMem_Read = fetch_req;
  assign inst_address = {fetch_pc_q, 2'b00};

  assign head_inst = buf_q[head_q];
  assign rs_addr   = head_inst[25:21];
  assign rt_addr   = head_inst[20:16];
  assign rs_data   = (rs_addr == '0) ? '0 : rf_q[rs_addr];
  assign rt_data   = (rt_addr == '0) ? '0 : rf_q[rt_addr];

  processor_alu u_alu (
    .inst    (head_inst),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .result  (alu_result),
    .rd      (alu_rd),
    .wen     (alu_wen)
  );

  assign commit      = retire;
  assign commit_pc   = retire ? {block_pc_q + 30'(head_q), 2'b00} : '0;
  assign commit_wen  = retire && alu_wen;
  assign commit_rd   = retire ? alu_rd : '0;
  assign commit_data = retire ? alu_result : '0;

  // A load overrides the retire update, which is what lets prefetch refill on the last retirement.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    block_pc_d = block_pc_q;
    head_d     = head_q;
    count_d    = count_q;
    if (retire) begin
      head_d  = head_q + 2'd1;
      count_d = count_q - 3'd1;
    end
    if (load) begin
      fetch_pc_d = fetch_pc_q + 30'd4;
      block_pc_d = fetch_pc_q;
      head_d     = 2'd0;
      count_d    = 3'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC[31:2];
      block_pc_q <= RESET_PC[31:2];
      head_q     <= 2'd0;
      count_q    <= 3'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      block_pc_q <= block_pc_d;
      head_q     <= head_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < BUF_N; k++) begin
        buf_q[k] <= fetch_word[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
    end else if (commit_wen) begin
      rf_q[commit_rd] <= commit_data;
    end
  end

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed vector table, fetch-stall and mid-block reset
// sequences, and a random instruction stream checked against an architectural register model.
module tb_processor;

  localparam logic [31:0] MEM_WORDS = 32'd20100;
  localparam int          N_RAND    = 20000;

  logic        clk;
  logic        rst;
  logic [31:0] inst_address;
  logic        InstMem_Read;
  logic        InstMem_Ready;
  logic [31:0] inst1_in, inst2_in, inst3_in, inst4_in;
  logic        commit;
  logic [31:0] commit_pc;
  logic        commit_wen;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] widx;
  logic [31:0] ref_rf [32];

  int total;
  int bad;

  processor #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_address  (inst_address),
    .InstMem_Read  (InstMem_Read),
    .InstMem_Ready (InstMem_Ready),
    .inst1_in      (inst1_in),
    .inst2_in      (inst2_in),
    .inst3_in      (inst3_in),
    .inst4_in      (inst4_in),
    .commit        (commit),
    .commit_pc     (commit_pc),
    .commit_wen    (commit_wen),
    .commit_rd     (commit_rd),
    .commit_data   (commit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign widx     = inst_address >> 2;
  assign inst1_in = (widx + 32'd0 < MEM_WORDS) ? mem[widx + 32'd0] : 32'h0;
  assign inst2_in = (widx + 32'd1 < MEM_WORDS) ? mem[widx + 32'd1] : 32'h0;
  assign inst3_in = (widx + 32'd2 < MEM_WORDS) ? mem[widx + 32'd2] : 32'h0;
  assign inst4_in = (widx + 32'd3 < MEM_WORDS) ? mem[widx + 32'd3] : 32'h0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
  } vec_t;

  vec_t vt [16];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(1) == 0) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] fns [6];
    logic [4:0] a, b, c;
    int unsigned k;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h26; fns[5] = 6'h27;
    a = rand_reg(); b = rand_reg(); c = rand_reg();
    k = $urandom_range(10);
    case (k)
      0: return enc_i(6'h0D, a, b, 16'($urandom));
      1: return enc_i(6'h0C, a, b, 16'($urandom));
      2: return enc_i(6'h0E, a, b, 16'($urandom));
      3: return enc_i(6'h08, a, b, 16'($urandom));
      4: return enc_i(6'h0F, 5'd0, b, 16'($urandom));
      default: return enc_r(a, b, c, fns[k - 5]);
    endcase
  endfunction

  // Architectural reference: execute one word against ref_rf, return what must retire.
  task automatic ref_exec(input logic [31:0] ins, output logic wen_e, output logic [4:0] rd_e,
                          output logic [31:0] data_e, output logic chk_d);
    logic [31:0] a, b, val;
    logic [4:0]  rd;
    logic        ok;
    a  = ref_rf[ins[25:21]];
    b  = ref_rf[ins[20:16]];
    ok = 1'b1;
    rd = ins[20:16];
    val = 32'h0;
    case (ins[31:26])
      6'h0D: val = a | {16'h0, ins[15:0]};
      6'h0C: val = a & {16'h0, ins[15:0]};
      6'h0E: val = a ^ {16'h0, ins[15:0]};
      6'h08: val = a + {{16{ins[15]}}, ins[15:0]};
      6'h0F: val = {ins[15:0], 16'h0};
      6'h00: begin
        rd = ins[15:11];
        case (ins[5:0])
          6'h20: val = a + b;
          6'h22: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h26: val = a ^ b;
          6'h27: val = ~(a | b);
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      rd  = 5'd0;
      val = 32'h0;
    end
    if (ok && rd != 5'd0) ref_rf[rd] = val;
    wen_e  = ok && (rd != 5'd0);
    rd_e   = rd;
    data_e = val;
    chk_d  = !(ok && rd == 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic cmp_commit(input string nm, input logic [31:0] pc_e, input logic wen_e,
                            input logic [4:0] rd_e, input logic [31:0] data_e,
                            input logic chk_d, input logic verbose);
    logic ok;
    total++;
    ok = (commit === 1'b1) && (commit_pc === pc_e) && (commit_wen === wen_e) &&
         (!wen_e || commit_rd === rd_e) && (!chk_d || commit_data === data_e);
    if (!ok) begin
      bad++;
      $display("FAIL %s: got commit=%0b pc=%h wen=%0b rd=%0d data=%h want pc=%h wen=%0b rd=%0d data=%h",
               nm, commit, commit_pc, commit_wen, commit_rd, commit_data, pc_e, wen_e, rd_e, data_e);
    end else if (verbose) begin
      $display("commit %s pc=%h wen=%0b rd=%0d data=%h", nm, commit_pc, commit_wen, commit_rd, commit_data);
    end
  endtask

  // Steps until commit is seen at a negedge, up to a bound; reports extra steps taken.
  task automatic wait_commit(output logic seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    for (int c = 0; c < 16; c++) begin
      if (commit === 1'b1) begin
        seen = 1'b1;
        return;
      end
      step();
      waited++;
    end
  endtask

  initial begin
    logic        seen;
    int          waited;
    int          n, cyc, c0, win;
    logic [31:0] exp_pc;
    logic        w_e, c_e;
    logic [4:0]  r_e;
    logic [31:0] d_e;

    total = 0;
    bad   = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;

    vt[0]  = '{"ori_r1",      enc_i(6'h0D, 5'd0, 5'd1, 16'h1234), 1'b1, 5'd1,  32'h0000_1234, 1'b1};
    vt[1]  = '{"lui_r2",      enc_i(6'h0F, 5'd0, 5'd2, 16'hABCD), 1'b1, 5'd2,  32'hABCD_0000, 1'b1};
    vt[2]  = '{"addi_r3",     enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF), 1'b1, 5'd3,  32'h0000_1233, 1'b1};
    vt[3]  = '{"sub_r4",      enc_r(5'd0, 5'd1, 5'd4, 6'h22),     1'b1, 5'd4,  32'hFFFF_EDCC, 1'b1};
    vt[4]  = '{"nor_r5",      enc_r(5'd1, 5'd2, 5'd5, 6'h27),     1'b1, 5'd5,  32'h5432_EDCB, 1'b1};
    vt[5]  = '{"xor_r6",      enc_r(5'd1, 5'd2, 5'd6, 6'h26),     1'b1, 5'd6,  32'hABCD_1234, 1'b1};
    vt[6]  = '{"ori_r0",      enc_i(6'h0D, 5'd0, 5'd0, 16'hFFFF), 1'b0, 5'd0,  32'h0,         1'b0};
    vt[7]  = '{"op3f_nop",    {6'h3F, 26'h0},                      1'b0, 5'd0,  32'h0,         1'b1};
    vt[8]  = '{"add_r8_r0",   enc_r(5'd0, 5'd0, 5'd8, 6'h20),     1'b1, 5'd8,  32'h0,         1'b1};
    vt[9]  = '{"or_r7",       enc_r(5'd6, 5'd0, 5'd7, 6'h25),     1'b1, 5'd7,  32'hABCD_1234, 1'b1};
    vt[10] = '{"andi_r9",     enc_i(6'h0C, 5'd5, 5'd9, 16'hFFFF), 1'b1, 5'd9,  32'h0000_EDCB, 1'b1};
    vt[11] = '{"xori_r10",    enc_i(6'h0E, 5'd1, 5'd10, 16'hFFFF),1'b1, 5'd10, 32'h0000_EDCB, 1'b1};
    vt[12] = '{"add_wrap",    enc_r(5'd2, 5'd2, 5'd11, 6'h20),    1'b1, 5'd11, 32'h579A_0000, 1'b1};
    vt[13] = '{"funct3f_nop", enc_r(5'd1, 5'd2, 5'd14, 6'h3F),    1'b0, 5'd0,  32'h0,         1'b1};
    vt[14] = '{"addi_neg",    enc_i(6'h08, 5'd0, 5'd12, 16'h8000),1'b1, 5'd12, 32'hFFFF_8000, 1'b1};
    vt[15] = '{"sub_r13",     enc_r(5'd1, 5'd2, 5'd13, 6'h22),    1'b1, 5'd13, 32'h5433_1234, 1'b1};
    for (int i = 0; i < 16; i++) mem[i] = vt[i].inst;

    // Reset for one cycle with Ready tied high.
    rst           = 1'b1;
    InstMem_Ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_read_commit", {62'h0, InstMem_Read, commit}, 64'h0);
    rst = 1'b0;
    #1;
    chk("first_fetch", {31'h0, InstMem_Read, inst_address, commit}, {31'h0, 1'b1, 32'h0, 1'b0});

    for (int i = 0; i < 16; i++) begin
      step();
      wait_commit(seen, waited);
      if (i == 0) chk("first_commit_latency", 64'(waited), 64'd0);
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL %s: no commit within bound", vt[i].name);
      end else begin
        cmp_commit(vt[i].name, 32'(4 * i), vt[i].wen, vt[i].rd, vt[i].data, vt[i].chk_data, 1'b1);
      end
      if (i == 2) InstMem_Ready = 1'b0;
      if (i == 3) begin
        for (int s = 0; s < 3; s++) begin
          step();
          chk("ready_stall", {31'h0, InstMem_Read, inst_address, commit}, {31'h0, 1'b1, 32'h10, 1'b0});
        end
        InstMem_Ready = 1'b1;
      end
    end

    // Reset in the middle of a fetched block: nothing buffered may retire afterwards.
    for (int i = 0; i < N_RAND; i++) mem[i] = rand_inst();
    step();
    wait_commit(seen, waited);
    chk("block64_commit_pc", {31'h0, commit, commit_pc}, {31'h0, 1'b1, 32'h40});
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {62'h0, InstMem_Read, commit}, 64'h0);
    step();
    chk("midreset_hold", {62'h0, InstMem_Read, commit}, 64'h0);
    rst = 1'b0;
    #1;
    chk("post_reset_fetch", {31'h0, InstMem_Read, inst_address, commit}, {31'h0, 1'b1, 32'h0, 1'b0});

    // Random stream against the register model; second half runs with Ready high to measure rate.
    exp_pc = 32'h0;
    n   = 0;
    cyc = 0;
    c0  = -1;
    win = 0;
    while (n < N_RAND && cyc < 80000) begin
      if (commit === 1'b1) begin
        ref_exec(mem[exp_pc >> 2], w_e, r_e, d_e, c_e);
        cmp_commit("rand", exp_pc, w_e, r_e, d_e, c_e, 1'b0);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      if (n >= N_RAND / 2 && c0 < 0) c0 = cyc;
      if (c0 >= 0 && cyc >= c0 + 20 && cyc < c0 + 120 && commit === 1'b1) win++;
      InstMem_Ready = (n < N_RAND / 2) ? ($urandom_range(3) != 0) : 1'b1;
      step();
      cyc++;
    end
    chk("random_stream_done", 64'(n), 64'(N_RAND));
`ifdef PROCESSOR_PREFETCH_EN
    chk("throughput_100_cycles", 64'(win), 64'd100);
`else
    chk("throughput_100_cycles", 64'(win), 64'd80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
